regfile_rename: RTL and testbench
=================================

Name: regfile_rename

Overview:
- Architectural register file with rename tags; sits directly downstream of the reorder buffer and upstream of issue/reservation stations.
- Consumes ROB commit writes (rd index, value, ROB tag) and records decode-time renames (rd bound to new ROB tag).
- Serves two combinational operand lookups per cycle: value if committed, else the producing ROB tag.
- Flush clears all pending renames on misprediction.

Parameters:
- XLEN, 32, data width of each register.
- TAG_W, 4, ROB tag width (ROB depth = 2**TAG_W).
- NREG, 32, number of architectural registers; index width 5.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when 0, no state changes.
- flush  in  1  misprediction clear of all busy bits.
- issue_en  in  1  rename request this cycle.
- issue_rd  in  5  destination register being renamed.
- issue_tag  in  TAG_W  ROB tag allocated to issue_rd.
- commit_en  in  1  ROB commit this cycle.
- commit_rd  in  5  committed destination register.
- commit_tag  in  TAG_W  ROB tag of committing entry.
- commit_val  in  XLEN  committed value.
- rs1_idx  in  5  source 1 index.
- rs2_idx  in  5  source 2 index.
- rs1_val  out  XLEN  source 1 value (valid when rs1_busy=0).
- rs1_busy  out  1  source 1 waits on a ROB tag.
- rs1_tag  out  TAG_W  producing tag when busy, else 0.
- rs2_val  out  XLEN  as rs1.
- rs2_busy  out  1  as rs1.
- rs2_tag  out  TAG_W  as rs1.

Behaviour:
- State per register: val[XLEN], busy, tag[TAG_W]. x0: val, busy, tag permanently 0; writes and renames to x0 ignored.
- Reset (rst=1 at edge): all val=0, busy=0, tag=0; overrides rdy, flush, issue, commit. Mid-operation reset discards pending renames.
- rdy=0: no updates at edge; lookup outputs remain combinationally valid.
- Commit (commit_en, rdy, commit_rd!=0): val[commit_rd]<=commit_val unconditionally. busy cleared only if busy=1, tag==commit_tag, and no same-cycle rename of the same rd.
- Rename (issue_en, rdy, !flush, issue_rd!=0): busy<=1, tag<=issue_tag. Same rd as commit in same cycle: value written, new busy/tag win.
- Flush (rdy): all busy<=0, tags<=0; same-cycle issue ignored; same-cycle commit still writes val.
- Lookup (zero latency, combinational):
  - idx=0 -> val 0, busy 0, tag 0.
  - busy=0 -> stored val, tag 0.
  - busy=1 and commit_en with commit_rd==idx and commit_tag==tag -> bypass: val=commit_val, busy 0, tag 0.
  - otherwise busy=1, tag=stored tag, val=stored val (don't-care).
  - Lookups reflect pre-issue state: an instruction renaming rd=rs1 sees the old mapping (e.g. addi x5,x5,1).
- Bypass depends only on commit inputs, not on rdy or flush.
- No full/empty conditions; tag wrap-around is harmless since matching is exact-equality against the stored tag.

Test Plan:
- Reset then read rs1=7, rs2=0 -> val 0, busy 0, tag 0 on both.
- Issue rd=5 tag=3; next cycle read rs1=5 -> busy 1, tag 3; commit rd=5 tag=3 val=0xDEADBEEF -> same-cycle bypass val 0xDEADBEEF busy 0; next cycle stored val 0xDEADBEEF, busy 0.
- Issue rd=5 tag=3, then rd=5 tag=9; commit rd=5 tag=3 val=0x11 -> val=0x11 written, busy stays 1, tag 9; read shows busy 1 tag 9.
- Same cycle: commit rd=6 tag=2 val=0x22, issue rd=6 tag=4 (x6 busy tag 2) -> after edge val 0x22, busy 1, tag 4.
- Rename x1,x2,x3 (tags 1,2,3); flush with issue rd=4 tag=5 -> all busy 0, x4 not renamed; rdy=0 with issue rd=8 -> x8 unchanged.
- Issue rd=0 tag=6 and commit rd=0 val=0xFF -> x0 reads val 0, busy 0, tag 0.

Source files
------------

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags. It takes commit writes from the
// ROB and decode-time renames, and serves two zero-latency operand lookups with commit bypass.
module regfile_rename #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned NREG  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    issue_en,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  input  logic [TAG_W-1:0]        issue_tag,
  input  logic                    commit_en,
  input  logic [$clog2(NREG)-1:0] commit_rd,
  input  logic [TAG_W-1:0]        commit_tag,
  input  logic [XLEN-1:0]         commit_val,
  input  logic [$clog2(NREG)-1:0] rs1_idx,
  input  logic [$clog2(NREG)-1:0] rs2_idx,
  output logic [XLEN-1:0]         rs1_val,
  output logic                    rs1_busy,
  output logic [TAG_W-1:0]        rs1_tag,
  output logic [XLEN-1:0]         rs2_val,
  output logic                    rs2_busy,
  output logic [TAG_W-1:0]        rs2_tag
);

  localparam int unsigned IdxW = $clog2(NREG);

  logic [XLEN-1:0]  val_q  [NREG];
  logic [XLEN-1:0]  val_d  [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;

  logic commit_ok;
  logic issue_ok;
  logic commit_clears;

  assign commit_ok     = rdy && commit_en && (commit_rd != '0);
  assign issue_ok      = rdy && issue_en && !flush && (issue_rd != '0);
  assign commit_clears = busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);

  // Priority: flush clears every rename, a same-cycle rename beats the commit's busy clear.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_ok) begin
      val_d[commit_rd] = commit_val;
      if (commit_clears) begin
        busy_d[commit_rd] = 1'b0;
        tag_d[commit_rd]  = '0;
      end
    end
    if (rdy && flush) begin
      busy_d = '0;
      for (int i = 0; i < NREG; i++) begin
        tag_d[i] = '0;
      end
    end else if (issue_ok) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_tag;
    end
    // x0 is hardwired to zero regardless of traffic.
    val_d[0]  = '0;
    tag_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Lookups see pre-edge state; a matching commit this cycle is forwarded regardless of rdy/flush.
  function automatic logic [XLEN+TAG_W:0] lookup(input logic [IdxW-1:0] idx);
    logic [XLEN-1:0]  v;
    logic             b;
    logic [TAG_W-1:0] t;
    v = '0;
    b = 1'b0;
    t = '0;
    if (idx != '0) begin
      if (!busy_q[idx]) begin
        v = val_q[idx];
      end else if (commit_en && (commit_rd == idx) && (commit_tag == tag_q[idx])) begin
        v = commit_val;
      end else begin
        v = val_q[idx];
        b = 1'b1;
        t = tag_q[idx];
      end
    end
    return {v, b, t};
  endfunction

  always_comb begin
    {rs1_val, rs1_busy, rs1_tag} = lookup(rs1_idx);
    {rs2_val, rs2_busy, rs2_tag} = lookup(rs2_idx);
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: rename, commit, bypass, flush, stall and x0 behaviour.
module tb_regfile_rename;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [3:0]  issue_tag = '0;
  logic        commit_en = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [3:0]  commit_tag = '0;
  logic [31:0] commit_val = '0;
  logic [4:0]  rs1_idx = '0;
  logic [4:0]  rs2_idx = '0;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;

  int passed = 0;
  int total = 0;

  regfile_rename #(.XLEN(32), .TAG_W(4), .NREG(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .issue_tag  (issue_tag),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rs1_val    (rs1_val),
    .rs1_busy   (rs1_busy),
    .rs1_tag    (rs1_tag),
    .rs2_val    (rs2_val),
    .rs2_busy   (rs2_busy),
    .rs2_tag    (rs2_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic chk_rs1(input string name, input logic [31:0] v, input logic b,
                         input logic [3:0] t);
    chk({name, ".val"}, rs1_val, v);
    chk({name, ".busy"}, {31'd0, rs1_busy}, {31'd0, b});
    chk({name, ".tag"}, {28'd0, rs1_tag}, {28'd0, t});
  endtask

  task automatic chk_busy1(input string name, input logic b, input logic [3:0] t);
    chk({name, ".busy"}, {31'd0, rs1_busy}, {31'd0, b});
    chk({name, ".tag"}, {28'd0, rs1_tag}, {28'd0, t});
  endtask

  initial begin
    // Reset, then read x7 and x0.
    tick();
    rst = 1'b0;
    rs1_idx = 5'd7;
    rs2_idx = 5'd0;
    #1;
    chk_rs1("rst_x7", 32'h0, 1'b0, 4'h0);
    chk("rst_x0.val", rs2_val, 32'h0);
    chk("rst_x0.busy", {31'd0, rs2_busy}, 32'h0);
    chk("rst_x0.tag", {28'd0, rs2_tag}, 32'h0);

    // Rename x5 -> tag 3, then commit with same-cycle bypass.
    issue_en = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
    tick();
    issue_en = 1'b0;
    rs1_idx = 5'd5;
    #1;
    chk_busy1("x5_renamed", 1'b1, 4'd3);
    commit_en = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_val = 32'hDEADBEEF;
    #1;
    chk_rs1("x5_bypass", 32'hDEADBEEF, 1'b0, 4'h0);
    tick();
    commit_en = 1'b0;
    #1;
    chk_rs1("x5_committed", 32'hDEADBEEF, 1'b0, 4'h0);

    // Stale commit: newer rename (tag 9) must survive.
    issue_en = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
    tick();
    issue_tag = 4'd9;
    tick();
    issue_en = 1'b0;
    commit_en = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_val = 32'h11;
    #1;
    chk_busy1("x5_stale_comb", 1'b1, 4'd9);
    tick();
    commit_en = 1'b0;
    #1;
    chk_busy1("x5_stale_after", 1'b1, 4'd9);

    // Commit and rename of x6 in the same cycle.
    issue_en = 1'b1; issue_rd = 5'd6; issue_tag = 4'd2;
    tick();
    issue_tag = 4'd4;
    commit_en = 1'b1; commit_rd = 5'd6; commit_tag = 4'd2; commit_val = 32'h22;
    rs1_idx = 5'd6;
    #1;
    chk_rs1("x6_pre_issue_bypass", 32'h22, 1'b0, 4'h0);
    tick();
    issue_en = 1'b0; commit_en = 1'b0;
    #1;
    chk_busy1("x6_rename_wins", 1'b1, 4'd4);

    // Rename x1..x3, then flush with an issue to x4 and a commit to x7.
    issue_en = 1'b1;
    issue_rd = 5'd1; issue_tag = 4'd1; tick();
    issue_rd = 5'd2; issue_tag = 4'd2; tick();
    issue_rd = 5'd3; issue_tag = 4'd3; tick();
    rs1_idx = 5'd2;
    issue_en = 1'b0;
    #1;
    chk_busy1("x2_renamed", 1'b1, 4'd2);
    flush = 1'b1;
    issue_en = 1'b1; issue_rd = 5'd4; issue_tag = 4'd5;
    commit_en = 1'b1; commit_rd = 5'd7; commit_tag = 4'd0; commit_val = 32'h77;
    tick();
    flush = 1'b0; issue_en = 1'b0; commit_en = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      rs1_idx = 5'(r);
      #1;
      chk_busy1($sformatf("flush_x%0d", r), 1'b0, 4'h0);
    end
    rs1_idx = 5'd5; #1;
    chk_rs1("flush_x5", 32'h11, 1'b0, 4'h0);
    rs1_idx = 5'd6; #1;
    chk_rs1("flush_x6", 32'h22, 1'b0, 4'h0);
    rs1_idx = 5'd7; #1;
    chk_rs1("flush_commit_x7", 32'h77, 1'b0, 4'h0);

    // Stall: rdy=0 blocks rename of x8 and commit to x9.
    rdy = 1'b0;
    issue_en = 1'b1; issue_rd = 5'd8; issue_tag = 4'd1;
    commit_en = 1'b1; commit_rd = 5'd9; commit_tag = 4'd0; commit_val = 32'h99;
    tick();
    rdy = 1'b1; issue_en = 1'b0; commit_en = 1'b0;
    rs1_idx = 5'd8; rs2_idx = 5'd9;
    #1;
    chk_busy1("stall_x8", 1'b0, 4'h0);
    chk("stall_x9.val", rs2_val, 32'h0);

    // Bypass is independent of rdy.
    issue_en = 1'b1; issue_rd = 5'd12; issue_tag = 4'd7;
    tick();
    issue_en = 1'b0;
    rdy = 1'b0;
    rs2_idx = 5'd12;
    commit_en = 1'b1; commit_rd = 5'd12; commit_tag = 4'd7; commit_val = 32'hAB;
    #1;
    chk("stall_bypass.val", rs2_val, 32'hAB);
    chk("stall_bypass.busy", {31'd0, rs2_busy}, 32'h0);
    tick();
    commit_en = 1'b0;
    #1;
    chk("stall_keep.busy", {31'd0, rs2_busy}, 32'h1);
    chk("stall_keep.tag", {28'd0, rs2_tag}, 32'h7);
    rdy = 1'b1;

    // x0 ignores renames and commits.
    issue_en = 1'b1; issue_rd = 5'd0; issue_tag = 4'd6;
    commit_en = 1'b1; commit_rd = 5'd0; commit_tag = 4'd0; commit_val = 32'hFF;
    rs1_idx = 5'd0;
    #1;
    chk_rs1("x0_comb", 32'h0, 1'b0, 4'h0);
    tick();
    issue_en = 1'b0; commit_en = 1'b0;
    #1;
    chk_rs1("x0_after", 32'h0, 1'b0, 4'h0);

    // Mid-operation reset overrides a pending rename and a commit.
    issue_en = 1'b1; issue_rd = 5'd10; issue_tag = 4'd5;
    tick();
    issue_en = 1'b0;
    rst = 1'b1;
    commit_en = 1'b1; commit_rd = 5'd11; commit_tag = 4'd0; commit_val = 32'h5;
    tick();
    rst = 1'b0; commit_en = 1'b0;
    rs1_idx = 5'd10; rs2_idx = 5'd11;
    #1;
    chk_busy1("rst_mid_x10", 1'b0, 4'h0);
    chk("rst_mid_x11.val", rs2_val, 32'h0);
    rs1_idx = 5'd5; #1;
    chk_rs1("rst_mid_x5", 32'h0, 1'b0, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
